store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 126 ++++++++++++
 tb/tb_store_buffer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the MEM stage and data memory.
// Stores are queued in a small circular FIFO and written to memory in program
// order whenever the memory port is not needed by a load. Loads bypass the
// queue, forwarding the youngest matching buffered store when one exists.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 21,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_MemWrite,
  input  logic          cpu_MemRead,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          stall,
  output logic          empty,
  output logic          mem_MemWrite,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_write,
  input  logic [DW-1:0] mem_read
);

  // Pointer width indexes DEPTH slots; the count needs one more bit to reach DEPTH.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Entry storage is never reset: a slot is only meaningful while it lies
  // within the count entries starting at head.
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          full;
  logic          load;
  logic          enq;
  logic          drain;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic [PW-1:0] scan_idx;

  // Occupancy flags and the per-cycle enqueue/drain decisions.
  // A store that arrives together with a read is treated as a store only,
  // but the raised read still keeps the memory port away from the drain
  // unless the buffer is full.
  always_comb begin
    full  = (count == FULL_COUNT);
    empty = (count == '0);
    load  = cpu_MemRead & ~cpu_MemWrite;
    enq   = cpu_MemWrite & ~full;
    drain = ~empty & (~cpu_MemRead | full);
    stall = full & (cpu_MemWrite | cpu_MemRead);
  end

  // Scan valid entries oldest to youngest so the last address match wins,
  // giving the youngest buffered store for forwarding.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_q[scan_idx] == cpu_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[scan_idx];
      end
    end
  end

  // Load result: forwarded store data, else memory data, else zero when no
  // load is being serviced this cycle.
  always_comb begin
    cpu_rdata = '0;
    if (load && !full) begin
      cpu_rdata = hit ? hit_data : mem_read;
    end
  end

  // Memory port: the head entry while draining, otherwise the CPU address
  // with the write strobe and write data held low.
  always_comb begin
    mem_MemWrite = drain;
    mem_addr     = cpu_addr;
    mem_write    = '0;
    if (drain) begin
      mem_addr  = addr_q[head];
      mem_write = data_q[head];
    end
  end

  // Head/tail pointers wrap naturally because DEPTH is a power of two; the
  // count moves only when exactly one of enqueue or drain happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + 1'b1;
      end
      if (drain) begin
        head <= head + 1'b1;
      end
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Capture an accepted store into the tail slot.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= cpu_addr;
      data_q[tail] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios followed by random traffic, checked
// every cycle against a queue-based model of the store buffer and memory.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 21;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk;
  logic          rst;
  logic          cpu_MemWrite;
  logic          cpu_MemRead;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          stall;
  logic          empty;
  logic          mem_MemWrite;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write;
  logic [DW-1:0] mem_read;

  // Environment memory (written from the DUT port) and model memory.
  logic [DW-1:0] dmem    [16];
  logic [DW-1:0] ref_mem [16];

  entry_t        model_q [$];
  logic          pend_drain;
  logic          pend_enq;
  entry_t        pend_entry;
  logic          mw_lat;
  logic [AW-1:0] ma_lat;
  logic [DW-1:0] md_lat;

  int tests_run;
  int tests_failed;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_MemWrite (cpu_MemWrite),
    .cpu_MemRead  (cpu_MemRead),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .stall        (stall),
    .empty        (empty),
    .mem_MemWrite (mem_MemWrite),
    .mem_addr     (mem_addr),
    .mem_write    (mem_write),
    .mem_read     (mem_read)
  );

  assign mem_read = dmem[mem_addr[3:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    cpu_MemWrite = w;
    cpu_MemRead  = r;
    cpu_addr     = a;
    cpu_wdata    = d;
    #1;
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  initial begin : compare
    logic          m_full;
    logic          m_empty;
    logic          m_load;
    logic          m_drain;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [DW-1:0] e_rdata;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_q.delete();
        pend_drain = 1'b0;
        pend_enq   = 1'b0;
        mw_lat     = 1'b0;
        checkOutput("rst_empty", 64'(empty), 64'd1);
        checkOutput("rst_stall", 64'(stall), 64'd0);
        checkOutput("rst_memwrite", 64'(mem_MemWrite), 64'd0);
      end else begin
        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        m_load  = cpu_MemRead && !cpu_MemWrite;
        m_drain = !m_empty && (!cpu_MemRead || m_full);
        e_addr  = m_drain ? model_q[0].addr : cpu_addr;
        e_wdata = m_drain ? model_q[0].data : '0;
        e_rdata = '0;
        if (m_load && !m_full) begin
          e_rdata = ref_mem[cpu_addr[3:0]];
          foreach (model_q[i]) begin
            if (model_q[i].addr == cpu_addr) e_rdata = model_q[i].data;
          end
        end
        checkOutput("empty", 64'(empty), 64'(m_empty));
        checkOutput("stall", 64'(stall), 64'(m_full && (cpu_MemWrite || cpu_MemRead)));
        checkOutput("mem_MemWrite", 64'(mem_MemWrite), 64'(m_drain));
        checkOutput("mem_addr", 64'(mem_addr), 64'(e_addr));
        checkOutput("mem_write", 64'(mem_write), 64'(e_wdata));
        if (!(m_load && m_full)) begin
          checkOutput("cpu_rdata", 64'(cpu_rdata), 64'(e_rdata));
        end
        pend_drain = m_drain;
        pend_enq   = cpu_MemWrite && !m_full;
        pend_entry = '{addr: cpu_addr, data: cpu_wdata};
        mw_lat     = mem_MemWrite;
        ma_lat     = mem_addr;
        md_lat     = mem_write;
      end
    end
  end

  // Clock-edge update of the model queue/memory and of the environment memory.
  initial begin : model_update
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (pend_drain) begin
          ref_mem[model_q[0].addr[3:0]] = model_q[0].data;
          void'(model_q.pop_front());
        end
        if (pend_enq) model_q.push_back(pend_entry);
        if (mw_lat) dmem[ma_lat[3:0]] = md_lat;
      end
      pend_drain = 1'b0;
      pend_enq   = 1'b0;
      mw_lat     = 1'b0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic drained;
    tests_run    = 0;
    tests_failed = 0;
    pend_drain   = 1'b0;
    pend_enq     = 1'b0;
    pend_entry   = '0;
    mw_lat       = 1'b0;
    ma_lat       = '0;
    md_lat       = '0;
    for (int i = 0; i < 16; i++) begin
      dmem[i]    = '0;
      ref_mem[i] = '0;
    end
    dmem[9]      = 32'h99;
    ref_mem[9]   = 32'h99;
    rst          = 1'b1;
    cpu_MemWrite = 1'b0;
    cpu_MemRead  = 1'b0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    #2;
    checkOutput("reset_empty", 64'(empty), 64'd1);
    checkOutput("reset_stall", 64'(stall), 64'd0);
    checkOutput("reset_memwrite", 64'(mem_MemWrite), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single store then idle: drains one cycle later.
    applyStimulus(1'b1, 1'b0, 21'd5, 32'h11);
    checkOutput("s1_no_write_yet", 64'(mem_MemWrite), 64'd0);
    applyStimulus(1'b0, 1'b0, 21'd0, 32'h0);
    checkOutput("s1_memwrite", 64'(mem_MemWrite), 64'd1);
    checkOutput("s1_addr", 64'(mem_addr), 64'd5);
    checkOutput("s1_data", 64'(mem_write), 64'h11);
    applyStimulus(1'b0, 1'b0, 21'd0, 32'h0);
    checkOutput("s1_empty", 64'(empty), 64'd1);
    checkOutput("s1_idle_write", 64'(mem_write), 64'd0);

    // Two stores to the same address then a forwarded load.
    applyStimulus(1'b1, 1'b0, 21'd5, 32'h11);
    applyStimulus(1'b1, 1'b0, 21'd5, 32'h22);
    checkOutput("s2_drain_first", 64'(mem_write), 64'h11);
    applyStimulus(1'b0, 1'b1, 21'd5, 32'h0);
    checkOutput("s2_forward", 64'(cpu_rdata), 64'h22);
    checkOutput("s2_no_drain", 64'(mem_MemWrite), 64'd0);
    applyStimulus(1'b0, 1'b0, 21'd0, 32'h0);
    checkOutput("s2_drain_second", 64'(mem_write), 64'h22);
    applyStimulus(1'b0, 1'b0, 21'd0, 32'h0);
    checkOutput("s2_empty", 64'(empty), 64'd1);

    // Fill to full with loads of address 9 interleaved.
    applyStimulus(1'b1, 1'b1, 21'd1, 32'hA1);
    checkOutput("s3_store_rdata", 64'(cpu_rdata), 64'd0);
    applyStimulus(1'b0, 1'b1, 21'd9, 32'h0);
    checkOutput("s3_load9_a", 64'(cpu_rdata), 64'h99);
    checkOutput("s3_load9_nodrain", 64'(mem_MemWrite), 64'd0);
    checkOutput("s3_load9_addr", 64'(mem_addr), 64'd9);
    applyStimulus(1'b1, 1'b1, 21'd2, 32'hA2);
    applyStimulus(1'b0, 1'b1, 21'd9, 32'h0);
    checkOutput("s3_load9_b", 64'(cpu_rdata), 64'h99);
    applyStimulus(1'b1, 1'b1, 21'd3, 32'hA3);
    applyStimulus(1'b1, 1'b1, 21'd4, 32'hA4);
    applyStimulus(1'b0, 1'b1, 21'd9, 32'h0);
    checkOutput("s3_full_stall", 64'(stall), 64'd1);
    checkOutput("s3_full_drain", 64'(mem_MemWrite), 64'd1);
    checkOutput("s3_full_addr", 64'(mem_addr), 64'd1);
    checkOutput("s3_full_data", 64'(mem_write), 64'hA1);

    // Refill, then a fifth store while full is refused and retried.
    applyStimulus(1'b1, 1'b1, 21'd5, 32'hA5);
    checkOutput("s4_refill_stall", 64'(stall), 64'd0);
    applyStimulus(1'b1, 1'b0, 21'd6, 32'hA6);
    checkOutput("s4_fifth_stall", 64'(stall), 64'd1);
    checkOutput("s4_fifth_drain", 64'(mem_write), 64'hA2);
    applyStimulus(1'b1, 1'b0, 21'd6, 32'hA6);
    checkOutput("s4_retry_stall", 64'(stall), 64'd0);
    checkOutput("s4_retry_drain", 64'(mem_addr), 64'd3);
    applyStimulus(1'b0, 1'b0, 21'd0, 32'h0);
    checkOutput("s5_drain_4", 64'(mem_write), 64'hA4);
    applyStimulus(1'b0, 1'b0, 21'd0, 32'h0);
    checkOutput("s5_drain_5", 64'(mem_write), 64'hA5);
    applyStimulus(1'b0, 1'b0, 21'd0, 32'h0);
    checkOutput("s5_drain_6_wrapped", 64'(mem_addr), 64'd6);
    checkOutput("s5_drain_6_data", 64'(mem_write), 64'hA6);
    applyStimulus(1'b0, 1'b0, 21'd0, 32'h0);
    checkOutput("s5_empty", 64'(empty), 64'd1);

    // Reset with three entries buffered discards them.
    applyStimulus(1'b1, 1'b1, 21'd7, 32'h77);
    applyStimulus(1'b1, 1'b1, 21'd8, 32'h88);
    applyStimulus(1'b1, 1'b1, 21'd10, 32'hAA);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    cpu_MemWrite = 1'b0;
    cpu_MemRead  = 1'b0;
    #1;
    checkOutput("s6_rst_empty", 64'(empty), 64'd1);
    checkOutput("s6_rst_memwrite", 64'(mem_MemWrite), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 21'd0, 32'h0);
    checkOutput("s6_after_memwrite_a", 64'(mem_MemWrite), 64'd0);
    applyStimulus(1'b0, 1'b0, 21'd0, 32'h0);
    checkOutput("s6_after_memwrite_b", 64'(mem_MemWrite), 64'd0);
    checkOutput("s6_mem7", 64'(dmem[7]), 64'd0);
    checkOutput("s6_mem10", 64'(dmem[10]), 64'd0);

    // Random traffic over a small address window with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        @(posedge clk);
        #1;
        rst          = 1'b1;
        cpu_MemWrite = 1'b0;
        cpu_MemRead  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
      end else begin
        applyStimulus(($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 45),
                      AW'($urandom_range(0, 15)), DW'($urandom));
      end
    end

    // Drain whatever is left and compare final memory images.
    drained = 1'b0;
    for (int k = 0; k < 4 * DEPTH && !drained; k++) begin
      applyStimulus(1'b0, 1'b0, 21'd0, 32'h0);
      if (empty) drained = 1'b1;
    end
    checkOutput("final_drain", 64'(drained), 64'd1);
    applyStimulus(1'b0, 1'b0, 21'd0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("final_mem", 64'(dmem[i]), 64'(ref_mem[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
